comparator_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `comparator_4bits` instance among `NREQ` requesters. Each requester offers an operand pair with a valid/ready handshake. The arbiter grants one requester, drives the shared comparator from registered operands, and captures the 3-bit result. It then returns the result, tagged with the requester id, on a back-pressurable response port. It sits between the requesting datapath blocks and the single comparator instance, which connects through the `cmp_*` ports.

---
 rtl/comparator_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_comparator_rr_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_rr_arbiter.sv
// Round-robin arbiter that time-shares one external comparator among NREQ requesters.
// Operands are registered into the comparator, and the result is returned tagged with the requester id.
module comparator_rr_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [NREQ-1:0]         req_ready,
   output logic [WIDTH-1:0]        cmp_a,
   output logic [WIDTH-1:0]        cmp_b,
   input  logic [2:0]              cmp_y,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IDW-1:0]          rsp_id,
   output logic [2:0]              rsp_y,
   output logic                    cmp_err
);

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      RSP
   } state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   ptr_nxt;
   logic [IDW-1:0]   grant;
   logic             found;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic             y_onehot;

   // Pick the valid requester whose rotational distance from ptr is smallest.
   always_comb begin : arb
      int unsigned p;
      int unsigned d;
      int unsigned best;
      p     = 32'(ptr);
      d     = 0;
      best  = NREQ;
      found = 1'b0;
      grant = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         d = (i >= p) ? (i - p) : (i + NREQ - p);
         if (req_valid[i] && (d < best)) begin
            best  = d;
            grant = IDW'(i);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_a = WIDTH'(req_a >> (32'(grant) * WIDTH));
      sel_b = WIDTH'(req_b >> (32'(grant) * WIDTH));
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && (state == IDLE) && found) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = (grant == IDW'(i));
         end
      end
   end

   always_comb begin
      y_onehot = (cmp_y == 3'b100) || (cmp_y == 3'b010) || (cmp_y == 3'b001);
      ptr_nxt  = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (found) state_nxt = CMP;
         CMP:     state_nxt = RSP;
         RSP:     if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         cmp_a     <= '0;
         cmp_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_y     <= '0;
         cmp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  cmp_a  <= sel_a;
                  cmp_b  <= sel_b;
                  rsp_id <= grant;
               end
            end
            CMP: begin
               rsp_y     <= cmp_y;
               rsp_valid <= 1'b1;
               if (!y_onehot) cmp_err <= 1'b1;
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr       <= ptr_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_comparator_rr_arbiter.sv
// Scoreboard bench for comparator_rr_arbiter: the bench plays the shared comparator,
// predicts grants and results at accept time, and compares them when responses appear.
module tb_comparator_rr_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned WIDTH = 4;
   localparam int unsigned IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_a, req_b;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      cmp_a, cmp_b;
   logic [2:0]            cmp_y;
   logic                  rsp_valid, rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [2:0]            rsp_y;
   logic                  cmp_err;
   logic                  inject_fault;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   comparator_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .cmp_a     (cmp_a),
      .cmp_b     (cmp_b),
      .cmp_y     (cmp_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .cmp_err   (cmp_err)
   );

   // The bench stands in for the shared comparator, with a fault override.
   always_comb cmp_y = inject_fault ? 3'b011 : {cmp_a > cmp_b, cmp_a == cmp_b, cmp_a < cmp_b};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return {a > b, a == b, a < b};
   endfunction

   typedef struct {
      logic [IDW-1:0]   id;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       y;
   } exp_t;

   typedef enum {M_IDLE, M_CMP, M_RSP} mstate_t;

   mstate_t        m_state = M_IDLE;
   int unsigned    m_ptr = 0;
   logic           m_err = 1'b0;
   bit             rsp_first = 1'b0;
   exp_t           sb[$];
   logic [IDW-1:0] log_id[$];
   logic [2:0]     log_y[$];
   int unsigned    rsp_count = 0;
   int unsigned    cyc = 0;
   int unsigned    acc_cyc = 0;
   int unsigned    acc_gap = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: state advances here at the negedge for the coming posedge.
   always @(negedge clk) begin : monitor
      int unsigned     g;
      int unsigned     idx;
      bit              hit;
      logic [NREQ-1:0] exp_rdy;
      exp_t            e;
      if (!rst_n) begin
         check_eq("ready_in_reset", 32'(req_ready), 0);
         m_state   = M_IDLE;
         m_ptr     = 0;
         m_err     = 1'b0;
         rsp_first = 1'b0;
         sb.delete();
      end else begin
         check_eq("cmp_err", 32'(cmp_err), 32'(m_err));
         case (m_state)
            M_IDLE: begin
               hit = 1'b0;
               g = 0;
               exp_rdy = '0;
               for (int unsigned k = 0; k < NREQ; k++) begin
                  idx = (m_ptr + k) % NREQ;
                  if (!hit && (((req_valid >> idx) & 4'b0001) != 0)) begin
                     hit = 1'b1;
                     g = idx;
                  end
               end
               if (hit) exp_rdy = NREQ'(1) << g;
               check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
               check_eq("rsp_valid_idle", 32'(rsp_valid), 0);
               if (hit) begin
                  e.id = IDW'(g);
                  e.a  = WIDTH'(req_a >> (g * WIDTH));
                  e.b  = WIDTH'(req_b >> (g * WIDTH));
                  e.y  = inject_fault ? 3'b011 : ref_cmp(e.a, e.b);
                  sb.push_back(e);
                  acc_gap = cyc - acc_cyc;
                  acc_cyc = cyc;
                  m_state = M_CMP;
               end
            end
            M_CMP: begin
               check_eq("req_ready_cmp", 32'(req_ready), 0);
               check_eq("rsp_valid_cmp", 32'(rsp_valid), 0);
               if (sb.size() > 0) begin
                  check_eq("cmp_a", 32'(cmp_a), 32'(sb[0].a));
                  check_eq("cmp_b", 32'(cmp_b), 32'(sb[0].b));
                  if (!(sb[0].y inside {3'b100, 3'b010, 3'b001})) m_err = 1'b1;
               end
               rsp_first = 1'b1;
               m_state = M_RSP;
            end
            M_RSP: begin
               if (rsp_first) check_eq("latency", cyc - acc_cyc, 2);
               rsp_first = 1'b0;
               check_eq("rsp_valid", 32'(rsp_valid), 1);
               check_eq("req_ready_rsp", 32'(req_ready), 0);
               if (sb.size() > 0) begin
                  check_eq("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                  check_eq("rsp_y", 32'(rsp_y), 32'(sb[0].y));
                  if (rsp_ready) begin
                     log_id.push_back(rsp_id);
                     log_y.push_back(rsp_y);
                     m_ptr = (32'(sb[0].id) + 1) % NREQ;
                     void'(sb.pop_front());
                     rsp_count++;
                     m_state = M_IDLE;
                  end
               end
            end
            default: m_state = M_IDLE;
         endcase
      end
   end

   task automatic cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input int unsigned n, input int unsigned budget);
      int unsigned target;
      target = rsp_count + n;
      for (int unsigned c = 0; c < budget && rsp_count < target; c++) @(posedge clk);
      #1;
      check_eq("rsp_done", 32'(rsp_count >= target), 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycles(2);
      rst_n = 1'b1;
   endtask

   logic [IDW-1:0] fair_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [2:0]     fair_y  [5] = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100};

   initial begin : stim
      int unsigned base;
      int unsigned cnt;
      rst_n        = 1'b0;
      req_valid    = '1;
      req_a        = {4'b0000, 4'b1000, 4'b1111, 4'b1101};
      req_b        = {4'b0000, 4'b1001, 4'b1111, 4'b1100};
      rsp_ready    = 1'b1;
      inject_fault = 1'b0;

      // Reset with every requester valid
      cycles(1);
      check_eq("rst_req_ready", 32'(req_ready), 0);
      check_eq("rst_cmp_a", 32'(cmp_a), 0);
      check_eq("rst_cmp_b", 32'(cmp_b), 0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
      check_eq("rst_rsp_id", 32'(rsp_id), 0);
      check_eq("rst_rsp_y", 32'(rsp_y), 0);
      check_eq("rst_cmp_err", 32'(cmp_err), 0);
      cycles(1);
      rst_n = 1'b1;
      wait_rsp(1, 20);
      req_valid = '0;
      check_eq("first_grant", 32'(log_id[log_id.size()-1]), 0);

      // Single requester, back-to-back
      do_reset();
      req_a[2*WIDTH +: WIDTH] = 4'b0001;
      req_b[2*WIDTH +: WIDTH] = 4'b0010;
      req_valid = 4'b0100;
      base = log_id.size();
      wait_rsp(3, 30);
      req_valid = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         check_eq("single_id", 32'(log_id[base+i]), 2);
         check_eq("single_y", 32'(log_y[base+i]), 32'(3'b001));
      end
      check_eq("period", acc_gap, 3);

      // Fairness with all four requesters
      do_reset();
      req_a = {4'b0000, 4'b1000, 4'b1111, 4'b1101};
      req_b = {4'b0000, 4'b1001, 4'b1111, 4'b1100};
      req_valid = '1;
      base = log_id.size();
      wait_rsp(5, 40);
      req_valid = '0;
      for (int unsigned i = 0; i < 5; i++) begin
         check_eq("fair_id", 32'(log_id[base+i]), 32'(fair_id[i]));
         check_eq("fair_y", 32'(log_y[base+i]), 32'(fair_y[i]));
      end

      // Back-pressure: response held five cycles, then the next id follows
      rsp_ready = 1'b0;
      req_valid = '1;
      for (int unsigned c = 0; c < 20 && !rsp_valid; c++) cycles(1);
      check_eq("bp_rsp_seen", 32'(rsp_valid), 1);
      cycles(5);
      check_eq("bp_held_valid", 32'(rsp_valid), 1);
      check_eq("bp_held_ready", 32'(req_ready), 0);
      base = log_id.size();
      rsp_ready = 1'b1;
      wait_rsp(2, 20);
      req_valid = '0;
      check_eq("bp_id0", 32'(log_id[base]), 1);
      check_eq("bp_id1", 32'(log_id[base+1]), 2);
      check_eq("bp_y1", 32'(log_y[base+1]), 32'(3'b001));

      // Reset while the comparator cycle is in progress
      req_valid = 4'b1000;
      for (int unsigned c = 0; c < 20 && m_state != M_CMP; c++) cycles(1);
      check_eq("mid_reached_cmp", 32'(m_state == M_CMP), 1);
      rst_n = 1'b0;
      req_valid = '0;
      cnt = rsp_count;
      cycles(2);
      rst_n = 1'b1;
      cycles(4);
      check_eq("mid_no_rsp", rsp_count, cnt);
      check_eq("mid_rsp_valid", 32'(rsp_valid), 0);
      req_valid = '1;
      wait_rsp(1, 20);
      req_valid = '0;
      check_eq("mid_ptr_zero", 32'(log_id[log_id.size()-1]), 0);

      // Comparator fault is passed through and sticks until reset
      req_valid = 4'b0010;
      inject_fault = 1'b1;
      wait_rsp(1, 20);
      inject_fault = 1'b0;
      req_valid = '0;
      check_eq("fault_y", 32'(log_y[log_y.size()-1]), 32'(3'b011));
      check_eq("fault_err", 32'(cmp_err), 1);
      base = log_id.size();
      req_valid = 4'b0101;
      wait_rsp(2, 30);
      req_valid = '0;
      check_eq("post_fault_id0", 32'(log_id[base]), 2);
      check_eq("post_fault_id1", 32'(log_id[base+1]), 0);
      check_eq("post_fault_y1", 32'(log_y[base+1]), 32'(3'b100));
      check_eq("err_sticky", 32'(cmp_err), 1);
      do_reset();
      check_eq("err_cleared", 32'(cmp_err), 0);

      cycles(2);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule
